// File: rtl/store_align_if.sv
// Store-align bus: MEM-stage store handshake plus the data-memory write port.
// The master modport is the alignment unit's view; slave is the pipeline/memory side.
interface store_align_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          st_valid_M;
   logic          st_ready_M;
   logic [2:0]    store_sel_M;
   logic [AW-1:0] addr_M;
   logic [DW-1:0] wdata_M;
   logic          mem_req;
   logic          mem_gnt;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic          misalign_err;
   logic          busy;

   modport master (
      input  st_valid_M, store_sel_M, addr_M, wdata_M, mem_gnt,
      output st_ready_M, mem_req, mem_addr, mem_wdata, mem_be, misalign_err, busy
   );

   modport slave (
      output st_valid_M, store_sel_M, addr_M, wdata_M, mem_gnt,
      input  st_ready_M, mem_req, mem_addr, mem_wdata, mem_be, misalign_err, busy
   );
endinterface

// File: rtl/store_align_unit.sv
// store_align_unit: turns an SB/SH/SW from the MEM stage into aligned word
// writes (lane-shifted data + byte enables) on the data-memory port.
// Optional feature macro STORE_SPLIT_EN: when defined, word-crossing stores are
// split into two beats; when undefined they are rejected with a one-cycle
// misalign_err pulse and never reach memory.
module store_align_unit #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   store_align_if.master bus
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

   state_e        state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic          err_q, err_d;
   logic          cross_q, cross_d;
`ifdef STORE_SPLIT_EN
   // second-beat fields are precomputed at accept time so beat 1 is a plain load
   logic [AW-1:0] b1_addr_q, b1_addr_d;
   logic [DW-1:0] b1_wdata_q, b1_wdata_d;
   logic [3:0]    b1_be_q, b1_be_d;
   logic [AW-1:0] in_b1_addr;
   logic [DW-1:0] in_b1_wdata;
`endif

   logic [3:0]    m;
   logic [1:0]    off;
   logic [7:0]    sh_be;
   logic          in_cross;
   logic [AW-1:0] in_b0_addr;
   logic [DW-1:0] in_b0_wdata;
   logic          last_gnt;
   logic          ready;
   logic          unused_sel2;

   assign unused_sel2 = bus.store_sel_M[2];

   // Decode the incoming store into mask, lane shift and both beats' fields.
   always_comb begin
      unique case (bus.store_sel_M[1:0])
         2'b00:   m = 4'b0001;
         2'b01:   m = 4'b0011;
         default: m = 4'b1111;
      endcase
      off         = bus.addr_M[1:0];
      sh_be       = {4'b0000, m} << off;
      in_cross    = |sh_be[7:4];
      in_b0_addr  = {bus.addr_M[AW-1:2], 2'b00};
      in_b0_wdata = bus.wdata_M << {off, 3'b000};
`ifdef STORE_SPLIT_EN
      in_b1_addr  = in_b0_addr + AW'(4);
      in_b1_wdata = bus.wdata_M >> (6'd32 - {1'b0, off, 3'b000});
`endif
   end

   // Last beat granted this cycle: the store completes and a new one may be taken.
   always_comb begin
      last_gnt = 1'b0;
      unique case (state_q)
         BEAT0:   last_gnt = bus.mem_gnt && !cross_q;
         BEAT1:   last_gnt = bus.mem_gnt;
         default: last_gnt = 1'b0;
      endcase
      ready = (state_q == IDLE) || last_gnt;
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      cross_d     = cross_q;
      err_d       = 1'b0;
`ifdef STORE_SPLIT_EN
      b1_addr_d   = b1_addr_q;
      b1_wdata_d  = b1_wdata_q;
      b1_be_d     = b1_be_q;
`endif
      unique case (state_q)
         BEAT0: begin
`ifdef STORE_SPLIT_EN
            if (bus.mem_gnt) begin
               if (cross_q) begin
                  state_d     = BEAT1;
                  mem_addr_d  = b1_addr_q;
                  mem_wdata_d = b1_wdata_q;
                  mem_be_d    = b1_be_q;
               end else begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end
            end
`else
            // crossing store: the error pulse cycle, nothing was issued
            if (cross_q) begin
               state_d = IDLE;
            end else if (bus.mem_gnt) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
`endif
         end
`ifdef STORE_SPLIT_EN
         BEAT1: begin
            if (bus.mem_gnt) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
`endif
         default: ;
      endcase
      // accept overrides completion so back-to-back stores have no bubble
      if (bus.st_valid_M && ready) begin
         state_d     = BEAT0;
         mem_addr_d  = in_b0_addr;
         mem_wdata_d = in_b0_wdata;
         mem_be_d    = sh_be[3:0];
         cross_d     = in_cross;
`ifdef STORE_SPLIT_EN
         mem_req_d   = 1'b1;
         b1_addr_d   = in_b1_addr;
         b1_wdata_d  = in_b1_wdata;
         b1_be_d     = sh_be[7:4];
`else
         mem_req_d   = !in_cross;
         err_d       = in_cross;
`endif
      end
   end

   // State and output registers; reset drops any in-flight store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         err_q       <= 1'b0;
         cross_q     <= 1'b0;
`ifdef STORE_SPLIT_EN
         b1_addr_q   <= '0;
         b1_wdata_q  <= '0;
         b1_be_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         err_q       <= err_d;
         cross_q     <= cross_d;
`ifdef STORE_SPLIT_EN
         b1_addr_q   <= b1_addr_d;
         b1_wdata_q  <= b1_wdata_d;
         b1_be_q     <= b1_be_d;
`endif
      end
   end

   assign bus.st_ready_M   = ready;
   assign bus.mem_req      = mem_req_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.mem_be       = mem_be_q;
   assign bus.misalign_err = err_q;
   assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit. Inputs change right after the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_store_align_unit;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   store_align_if #(.AW(32), .DW(32)) bus ();

   store_align_unit #(.AW(32), .DW(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = {8{be[k]}};
      return r;
   endfunction

   // one write beat on the memory port; only enabled lanes of data are compared
   task automatic beat(input string tag, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] data);
      check({tag, ".req"},  {31'b0, bus.mem_req}, 32'd1);
      check({tag, ".addr"}, bus.mem_addr, addr);
      check({tag, ".be"},   {28'b0, bus.mem_be}, {28'b0, be});
      check({tag, ".data"}, bus.mem_wdata & lane_mask(be), data & lane_mask(be));
   endtask

   task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] d, input logic g);
      bus.st_valid_M  = v;
      bus.store_sel_M = sel;
      bus.addr_M      = a;
      bus.wdata_M     = d;
      bus.mem_gnt     = g;
   endtask

   task automatic next_cyc();
      @(negedge clk);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);

      // reset state
      #1;
      check("rst.req",  {31'b0, bus.mem_req}, 32'd0);
      check("rst.addr", bus.mem_addr, 32'h0);
      check("rst.data", bus.mem_wdata, 32'h0);
      check("rst.be",   {28'b0, bus.mem_be}, 32'h0);
      check("rst.err",  {31'b0, bus.misalign_err}, 32'd0);
      check("rst.busy", {31'b0, bus.busy}, 32'd0);
      repeat (2) next_cyc();
      rst_n = 1'b1;
      #1;
      check("rel.ready", {31'b0, bus.st_ready_M}, 32'd1);

      // grant while idle is ignored
      next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1); #1;
      next_cyc(); #1;
      check("idle_gnt.req",  {31'b0, bus.mem_req}, 32'd0);
      check("idle_gnt.busy", {31'b0, bus.busy}, 32'd0);

      // SB 0x1003, grant tied high: single beat at N+1
      next_cyc(); drive(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 1'b1); #1;
      check("sb.acc_ready", {31'b0, bus.st_ready_M}, 32'd1);
      next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1); #1;
      beat("sb", 32'h0000_1000, 4'b1000, 32'hA500_0000);
      check("sb.done_ready", {31'b0, bus.st_ready_M}, 32'd1);
      check("sb.busy",       {31'b0, bus.busy}, 32'd1);
      next_cyc(); #1;
      check("sb.idle_req",  {31'b0, bus.mem_req}, 32'd0);
      check("sb.idle_busy", {31'b0, bus.busy}, 32'd0);

      // SH 0x2002 with grant withheld 3 cycles: fields stay stable
      next_cyc(); drive(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1'b0); #1;
      for (int i = 0; i < 3; i++) begin
         next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0); #1;
         beat($sformatf("sh.wait%0d", i), 32'h0000_2000, 4'b1100, 32'hBEEF_0000);
         check($sformatf("sh.wait%0d.ready", i), {31'b0, bus.st_ready_M}, 32'd0);
      end
      next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1); #1;
      beat("sh.gnt", 32'h0000_2000, 4'b1100, 32'hBEEF_0000);
      check("sh.gnt.ready", {31'b0, bus.st_ready_M}, 32'd1);
      next_cyc(); #1;
      check("sh.idle_req", {31'b0, bus.mem_req}, 32'd0);

      // back-to-back SW 0x4000 then SB 0x4005, no bubble
      next_cyc(); drive(1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 1'b1); #1;
      next_cyc(); drive(1'b1, 3'b100, 32'h0000_4005, 32'h0000_005A, 1'b1); #1;
      beat("b2b.sw", 32'h0000_4000, 4'b1111, 32'hCAFE_F00D);
      check("b2b.sw.ready", {31'b0, bus.st_ready_M}, 32'd1);
      next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1); #1;
      beat("b2b.sb", 32'h0000_4004, 4'b0010, 32'h0000_5A00);
      next_cyc(); #1;
      check("b2b.idle_req", {31'b0, bus.mem_req}, 32'd0);

`ifdef STORE_SPLIT_EN
      // SW 0x3001 split into two beats
      next_cyc(); drive(1'b1, 3'b010, 32'h0000_3001, 32'h1122_3344, 1'b1); #1;
      next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1); #1;
      beat("split.b0", 32'h0000_3000, 4'b1110, 32'h2233_4400);
      check("split.b0.ready", {31'b0, bus.st_ready_M}, 32'd0);
      next_cyc(); #1;
      beat("split.b1", 32'h0000_3004, 4'b0001, 32'h0000_0011);
      check("split.b1.ready", {31'b0, bus.st_ready_M}, 32'd1);
      next_cyc(); #1;
      check("split.idle_req", {31'b0, bus.mem_req}, 32'd0);

      // SH at the top word wraps the second beat to address 0
      next_cyc(); drive(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_AABB, 1'b1); #1;
      next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1); #1;
      beat("wrap.b0", 32'hFFFF_FFFC, 4'b1000, 32'hBB00_0000);
      next_cyc(); #1;
      beat("wrap.b1", 32'h0000_0000, 4'b0001, 32'h0000_00AA);

      // reset asserted mid-BEAT1
      next_cyc(); drive(1'b1, 3'b010, 32'h0000_3001, 32'h1122_3344, 1'b1); #1;
      next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1); #1;
      next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0); #1;
      check("mid.b1_req", {31'b0, bus.mem_req}, 32'd1);
`else
      // crossing SH 0x5003 rejected; following SW proceeds
      next_cyc(); drive(1'b1, 3'b001, 32'h0000_5003, 32'h0000_1234, 1'b1); #1;
      next_cyc(); drive(1'b1, 3'b010, 32'h0000_5000, 32'h0102_0304, 1'b1); #1;
      check("mis.req",   {31'b0, bus.mem_req}, 32'd0);
      check("mis.err",   {31'b0, bus.misalign_err}, 32'd1);
      check("mis.ready", {31'b0, bus.st_ready_M}, 32'd0);
      check("mis.busy",  {31'b0, bus.busy}, 32'd1);
      next_cyc(); #1;
      check("mis.err_off", {31'b0, bus.misalign_err}, 32'd0);
      check("mis.busy_off", {31'b0, bus.busy}, 32'd0);
      check("mis.ready_on", {31'b0, bus.st_ready_M}, 32'd1);
      next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1); #1;
      beat("mis.sw", 32'h0000_5000, 4'b1111, 32'h0102_0304);
      next_cyc(); #1;
      check("mis.idle_req", {31'b0, bus.mem_req}, 32'd0);

      // reset asserted while a beat waits for grant
      next_cyc(); drive(1'b1, 3'b010, 32'h0000_6000, 32'h5566_7788, 1'b0); #1;
      next_cyc(); drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0); #1;
      check("mid.b0_req", {31'b0, bus.mem_req}, 32'd1);
`endif
      rst_n = 1'b0;
      #1;
      check("mid.rst_req", {31'b0, bus.mem_req}, 32'd0);
      check("mid.rst_be",  {28'b0, bus.mem_be}, 32'h0);
      next_cyc();
      rst_n = 1'b1;
      #1;
      check("mid.rel_ready", {31'b0, bus.st_ready_M}, 32'd1);
      check("mid.rel_busy",  {31'b0, bus.busy}, 32'd0);
      next_cyc(); #1;
      check("mid.rel_req", {31'b0, bus.mem_req}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Store-side counterpart of the MEM-stage load alignment path.
- Accepts a store (SB/SH/SW) from the pipeline MEM stage and converts it into aligned word write transactions on the data-memory port.
  - Lane-shifted write data plus byte enables.
  - Word-crossing stores are split into two beats.
- Sits between the MEM-stage register and the data memory.
- Stalls the pipeline through a valid/ready handshake while a store is in flight.

Parameters:
- AW, 32, address width; mem_addr is always word aligned, so bits [1:0] are 0.
- DW, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid_M  in  1  MEM stage presents a store.
- st_ready_M  out  1  unit accepts the store this cycle; pipeline stalls while valid && !ready.
- store_sel_M  in  3  000=SB, 001=SH, 010=SW; bit2 ignored; [1:0]=11 treated as SW.
- addr_M  in  AW  byte address of the store.
- wdata_M  in  DW  store data, right-justified (byte in [7:0], half in [15:0]).
- mem_req  out  1  write request to data memory.
- mem_gnt  in  1  memory accepts the beat in the same cycle it is sampled with mem_req.
- mem_addr  out  AW  word-aligned write address.
- mem_wdata  out  DW  lane-shifted write data.
- mem_be  out  4  byte enables; bit k enables byte lane k.
- misalign_err  out  1  one-cycle pulse, word-crossing store rejected (only without STORE_SPLIT_EN).
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, misalign_err=0, busy=0, state=IDLE. st_ready_M=1 once reset is released.
- Reset is asynchronous. Asserting it mid-transaction drops mem_req immediately and discards the pending store.
- Byte mask m and offset:
  - m = 0001 (SB), 0011 (SH), 1111 (SW).
  - off = addr_M[1:0].
  - A store is word-crossing when (m << off) has any bit above bit 3: SH with off=3, or SW with off≠0.
- Beat 0 (every store):
  - mem_addr = {addr[AW-1:2],2'b00}
  - mem_be = (m << off)[3:0]
  - mem_wdata = (wdata << 8*off)[31:0]
- Beat 1 (crossing stores only):
  - mem_addr = beat-0 address + 4; wraps modulo 2^AW, so 0xFFFFFFFC goes to 0x00000000.
  - mem_be = m >> (4-off)
  - mem_wdata = wdata >> 8*(4-off)
- Lanes with be=0 carry don't-care data. The bench checks enabled lanes only.
- State machine states: IDLE, BEAT0, BEAT1.
  - IDLE: st_ready_M=1. On st_valid_M, latch sel/addr/data and go to BEAT0.
  - BEAT0: mem_req=1 with beat-0 fields.
    - On mem_gnt, go to BEAT1 if the store is crossing; otherwise the beat is done.
  - BEAT1: mem_req=1 with beat-1 fields. On mem_gnt the beat is done.
  - Done: st_ready_M=1 in the same cycle (last beat && mem_gnt).
    - If st_valid_M is also high, the new store is latched and the state goes directly to BEAT0 (back-to-back, no bubble).
    - Otherwise the state returns to IDLE.
- Otherwise st_ready_M=0 in BEAT0/BEAT1.
- mem_addr, mem_wdata and mem_be stay stable while mem_req && !mem_gnt. They are registered outputs.
- Latency: store accepted in cycle N → mem_req asserted in N+1. An aligned store with immediate grant completes in N+1; a crossing store completes in N+2.
- mem_gnt while mem_req=0 is ignored.

Optional Feature:
- Macro: STORE_SPLIT_EN.
- Defined: word-crossing stores are split into two beats as described above.
- Undefined:
  - A crossing store is accepted in IDLE but issues no mem_req.
  - misalign_err pulses for exactly one cycle (N+1) and the state returns to IDLE.
  - st_ready_M=0 during that cycle.
  - BEAT1 logic is not synthesized.
- Non-crossing stores behave identically with and without the macro.

Test Plan:
- Reset: hold rst_n=0, assert rst_n low mid-BEAT1 → mem_req=0 and mem_be=0 asynchronously; after release, st_ready_M=1, busy=0.
- SB addr=0x1003, wdata=0x000000A5, gnt tied 1 → one beat: mem_addr=0x1000, mem_be=1000, mem_wdata[31:24]=0xA5, done at N+1.
- SH addr=0x2002, wdata=0xBEEF, mem_gnt low 3 cycles then high → mem_req held 4 cycles with mem_addr=0x2000, be=1100, wdata[31:16]=0xBEEF stable throughout.
- SW addr=0x3001, wdata=0x11223344 (split on):
  - beat0 addr=0x3000, be=1110, wdata[31:8]=0x223344
  - beat1 addr=0x3004, be=0001, wdata[7:0]=0x11
  - st_ready_M low until beat1 grant.
- Back-to-back SW 0x4000 then SB 0x4005 with gnt=1 → beats on consecutive cycles (0x4000/1111, then 0x4004/0010), no bubble.
- Split off: SH addr=0x5003 → no mem_req, misalign_err=1 for one cycle, then IDLE; a following SW at 0x5000 proceeds normally.
